// File: rtl/rega_escalonador_if.sv
// Request, sensor and actuator bundle of the irrigation tank scheduler.
interface rega_escalonador_if;
  logic Req_asp;
  logic Req_got;
  logic Adub;
  logic Nv1;
  logic Nv0;
  logic Ve;
  logic Mist;
  logic Limp;
  logic Asp;
  logic Got;
  logic Done;
  logic Err;

  modport master (
    output Req_asp, Req_got, Adub, Nv1, Nv0,
    input  Ve, Mist, Limp, Asp, Got, Done, Err
  );

  modport slave (
    input  Req_asp, Req_got, Adub, Nv1, Nv0,
    output Ve, Mist, Limp, Asp, Got, Done, Err
  );
endinterface

// File: rtl/rega_escalonador.sv
// Shared irrigation tank scheduler: round-robin sprinkler/drip arbitration
// plus fill, mix and clean sequencing around each granted cycle.
module rega_escalonador #(
  parameter int CW     = 8,
  parameter int T_ASP  = 8,
  parameter int T_GOT  = 16,
  parameter int T_MIST = 4,
  parameter int T_LIMP = 4
) (
  input  logic clk,
  input  logic reset,
  rega_escalonador_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_MIX,
    S_IRRIG,
    S_CLEAN,
    S_ERRO
  } state_t;

  localparam logic G_ASP = 1'b0;
  localparam logic G_GOT = 1'b1;

  localparam logic [CW-1:0] L_ASP  = CW'(T_ASP);
  localparam logic [CW-1:0] L_GOT  = CW'(T_GOT);
  localparam logic [CW-1:0] L_MIST = CW'(T_MIST);
  localparam logic [CW-1:0] L_LIMP = CW'(T_LIMP);
  localparam logic [CW-1:0] L_ONE  = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_grant;
  logic          r_last;
  logic          r_adub;
  logic          r_mixed;
  logic          r_started;
  logic          r_done;

  logic          w_fault;
  logic          w_full;
  logic          w_any;
  logic          w_pick;
  logic [CW-1:0] w_pick_dur;
  logic [CW-1:0] w_dur;
  logic          w_irrig;

  assign w_fault = bus.Nv1 & ~bus.Nv0;
  assign w_full  = bus.Nv1 & bus.Nv0;
  assign w_any   = bus.Req_asp | bus.Req_got;

  // On a tie the requester not served last wins.
  assign w_pick = (bus.Req_asp & bus.Req_got) ? ~r_last :
                  (bus.Req_asp ? G_ASP : G_GOT);

  assign w_pick_dur = (w_pick  == G_GOT) ? L_GOT : L_ASP;
  assign w_dur      = (r_grant == G_GOT) ? L_GOT : L_ASP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_grant   <= G_ASP;
      r_last    <= G_GOT;
      r_adub    <= 1'b0;
      r_mixed   <= 1'b0;
      r_started <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fault && r_state != S_ERRO) begin
        r_state <= S_ERRO;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_any) begin
              r_grant   <= w_pick;
              r_adub    <= bus.Adub;
              r_mixed   <= 1'b0;
              r_started <= 1'b0;
              if (!bus.Nv0) begin
                r_state <= S_FILL;
              end else if (bus.Adub) begin
                r_state <= S_MIX;
                r_cnt   <= L_MIST;
              end else begin
                r_state   <= S_IRRIG;
                r_cnt     <= w_pick_dur;
                r_started <= 1'b1;
              end
            end
          end
          S_FILL: begin
            if (w_full) begin
              if (r_adub && !r_mixed) begin
                r_state <= S_MIX;
                r_cnt   <= L_MIST;
              end else begin
                r_state <= S_IRRIG;
                // A paused cycle resumes with its remaining count.
                if (!r_started) begin
                  r_cnt     <= w_dur;
                  r_started <= 1'b1;
                end
              end
            end
          end
          S_MIX: begin
            if (r_cnt == L_ONE) begin
              r_mixed <= 1'b1;
              r_state <= S_IRRIG;
              if (!r_started) begin
                r_cnt     <= w_dur;
                r_started <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - L_ONE;
            end
          end
          S_IRRIG: begin
            if (!bus.Nv0) begin
              r_state <= S_FILL;
            end else if (r_cnt == L_ONE) begin
              r_last <= r_grant;
              r_done <= 1'b1;
              if (r_adub) begin
                r_state <= S_CLEAN;
                r_cnt   <= L_LIMP;
              end else begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - L_ONE;
            end
          end
          S_CLEAN: begin
            r_cnt <= r_cnt - L_ONE;
            if (r_cnt == L_ONE) begin
              r_state <= S_IDLE;
            end
          end
          S_ERRO: begin
            r_state <= S_ERRO;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign w_irrig  = ~reset & (r_state == S_IRRIG) & bus.Nv0;
  assign bus.Ve   = ~reset & (r_state == S_FILL);
  assign bus.Mist = ~reset & (r_state == S_MIX);
  assign bus.Limp = ~reset & (r_state == S_CLEAN);
  assign bus.Err  = ~reset & (r_state == S_ERRO);
  assign bus.Asp  = w_irrig & (r_grant == G_ASP);
  assign bus.Got  = w_irrig & (r_grant == G_GOT);
  assign bus.Done = ~reset & r_done;

endmodule
